// File: rtl/bj_round_ctrl.sv
// Blackjack round controller: deals P,D,P,D, runs the player and dealer turns
// against an external card source, and resolves the round into a result code.
module bj_round_ctrl #(
  parameter int DEALER_STAND = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       deal_pressed,
  input  logic       hit_pressed,
  input  logic       stand_pressed,
  output logic       card_req,
  input  logic       card_ack,
  input  logic [3:0] card_rank,
  output logic [5:0] player_score,
  output logic [5:0] dealer_score,
  output logic [2:0] state_out,
  output logic [1:0] result
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DEAL_P  = 3'd1,
    DEAL_D  = 3'd2,
    PLAYER  = 3'd3,
    DEALER  = 3'd4,
    RESOLVE = 3'd5,
    DONE    = 3'd6
  } state_t;

  localparam logic [5:0] STAND_SCORE = 6'(DEALER_STAND);

  state_t      state_reg, state_next;
  logic [5:0]  player_score_reg, dealer_score_reg;
  logic [3:0]  player_soft_reg, dealer_soft_reg;
  logic [3:0]  player_cnt_reg, dealer_cnt_reg;
  logic        hit_pend_reg;
  logic [1:0]  result_reg, result_next;

  logic        rank_ok, is_ace, accept, to_dealer;
  logic        clear_hand, pend_set;
  logic [5:0]  card_val, base_score, sum_raw, sum_next;
  logic [3:0]  base_soft, soft_raw, soft_next;

  // Card value and the shared ace-adjusting adder for whichever hand is drawing.
  always_comb begin
    rank_ok   = (card_rank != 4'd0) && (card_rank <= 4'd13);
    is_ace    = (card_rank == 4'd1);
    card_val  = is_ace ? 6'd11 : (card_rank >= 4'd11) ? 6'd10 : {2'b00, card_rank};
    to_dealer = (state_reg == DEAL_D) || (state_reg == DEALER);
    base_score = to_dealer ? dealer_score_reg : player_score_reg;
    base_soft  = to_dealer ? dealer_soft_reg  : player_soft_reg;
    sum_raw   = base_score + card_val;
    soft_raw  = base_soft + {3'b000, is_ace};
    sum_next  = sum_raw;
    soft_next = soft_raw;
    if (sum_raw > 6'd21 && soft_raw != 4'd0) begin
      sum_next  = sum_raw - 6'd10;
      soft_next = soft_raw - 4'd1;
    end
  end

  always_comb begin
    card_req = 1'b0;
    case (state_reg)
      DEAL_P, DEAL_D: card_req = 1'b1;
      PLAYER:         card_req = hit_pend_reg;
      DEALER:         card_req = (dealer_score_reg < STAND_SCORE);
      default:        card_req = 1'b0;
    endcase
  end

  assign accept = card_req && card_ack && rank_ok;

  always_comb begin
    state_next  = state_reg;
    result_next = result_reg;
    clear_hand  = 1'b0;
    pend_set    = 1'b0;
    case (state_reg)
      IDLE, DONE: begin
        if (deal_pressed) begin
          clear_hand = 1'b1;
          state_next = DEAL_P;
        end
      end
      DEAL_P: if (accept) state_next = DEAL_D;
      DEAL_D: begin
        if (accept) state_next = (dealer_cnt_reg == 4'd1) ? PLAYER : DEAL_P;
      end
      PLAYER: begin
        // Automatic exits take priority; buttons are ignored while a hit is pending.
        if (player_score_reg > 6'd21)       state_next = RESOLVE;
        else if (player_score_reg == 6'd21) state_next = DEALER;
        else if (!hit_pend_reg) begin
          if (stand_pressed)    state_next = DEALER;
          else if (hit_pressed) pend_set   = 1'b1;
        end
      end
      DEALER: if (dealer_score_reg >= STAND_SCORE) state_next = RESOLVE;
      RESOLVE: begin
        if (player_score_reg > 6'd21)                     result_next = 2'b10;
        else if (dealer_score_reg > 6'd21)                result_next = 2'b01;
        else if (player_score_reg > dealer_score_reg)     result_next = 2'b01;
        else if (player_score_reg < dealer_score_reg)     result_next = 2'b10;
        else                                              result_next = 2'b11;
        state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      player_score_reg <= 6'd0;
      dealer_score_reg <= 6'd0;
      player_soft_reg  <= 4'd0;
      dealer_soft_reg  <= 4'd0;
      player_cnt_reg   <= 4'd0;
      dealer_cnt_reg   <= 4'd0;
      hit_pend_reg     <= 1'b0;
      result_reg       <= 2'b00;
    end else begin
      state_reg  <= state_next;
      result_reg <= result_next;
      if (clear_hand) begin
        player_score_reg <= 6'd0;
        dealer_score_reg <= 6'd0;
        player_soft_reg  <= 4'd0;
        dealer_soft_reg  <= 4'd0;
        player_cnt_reg   <= 4'd0;
        dealer_cnt_reg   <= 4'd0;
        hit_pend_reg     <= 1'b0;
        result_reg       <= 2'b00;
      end else if (accept) begin
        hit_pend_reg <= 1'b0;
        if (to_dealer) begin
          dealer_score_reg <= sum_next;
          dealer_soft_reg  <= soft_next;
          dealer_cnt_reg   <= dealer_cnt_reg + 4'd1;
        end else begin
          player_score_reg <= sum_next;
          player_soft_reg  <= soft_next;
          player_cnt_reg   <= player_cnt_reg + 4'd1;
        end
      end else if (pend_set) begin
        hit_pend_reg <= 1'b1;
      end
    end
  end

  assign player_score = player_score_reg;
  assign dealer_score = dealer_score_reg;
  assign state_out    = state_reg;
  assign result       = result_reg;

endmodule
